// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: writeback sources, regfile write port and decode bypass signals
interface regfile_wb_arbiter_if #(parameter int XLEN = 32, parameter int REG_AW = 5);
  logic              wb_hold;
  logic              a_valid;
  logic              a_ready;
  logic [REG_AW-1:0] a_rd;
  logic [XLEN-1:0]   a_wdata;
  logic              b_valid;
  logic              b_ready;
  logic [REG_AW-1:0] b_rd;
  logic [XLEN-1:0]   b_wdata;
  logic              reg_write;
  logic [REG_AW-1:0] rd;
  logic [XLEN-1:0]   rd_wdata;
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  logic              rs1_fwd;
  logic              rs2_fwd;
  logic [XLEN-1:0]   rs1_fwd_data;
  logic [XLEN-1:0]   rs2_fwd_data;
  modport master (
    output wb_hold, a_valid, a_rd, a_wdata, b_valid, b_rd, b_wdata, rs1, rs2,
    input  a_ready, b_ready, reg_write, rd, rd_wdata, rs1_fwd, rs2_fwd, rs1_fwd_data, rs2_fwd_data
  );
  modport slave (
    input  wb_hold, a_valid, a_rd, a_wdata, b_valid, b_rd, b_wdata, rs1, rs2,
    output a_ready, b_ready, reg_write, rd, rd_wdata, rs1_fwd, rs2_fwd, rs1_fwd_data, rs2_fwd_data
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin arbiter of two writeback sources into a one-entry write stage with read bypass
module regfile_wb_arbiter #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input logic                clk,
  input logic                reset_n,
  regfile_wb_arbiter_if.slave bus
);
  typedef enum logic {SRC_A, SRC_B} src_e;
  src_e              last;
  logic              s_valid;
  logic [REG_AW-1:0] s_rd;
  logic [XLEN-1:0]   s_data;
  logic              grant_ok, a_acc, b_acc, s_live;
  // Reset gates ready so a request in flight is never taken while the stage is cleared
  always_comb begin
    grant_ok = reset_n && !bus.wb_hold;
    a_acc    = grant_ok && bus.a_valid && (!bus.b_valid || last == SRC_B);
    b_acc    = grant_ok && bus.b_valid && (!bus.a_valid || last == SRC_A);
    s_live   = s_valid && (s_rd != '0);
  end
  assign bus.a_ready      = a_acc;
  assign bus.b_ready      = b_acc;
  assign bus.reg_write    = s_live;
  assign bus.rd           = s_rd;
  assign bus.rd_wdata     = s_data;
  assign bus.rs1_fwd      = s_live && (s_rd == bus.rs1);
  assign bus.rs2_fwd      = s_live && (s_rd == bus.rs2);
  assign bus.rs1_fwd_data = bus.rs1_fwd ? s_data : '0;
  assign bus.rs2_fwd_data = bus.rs2_fwd ? s_data : '0;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_valid <= 1'b0;
      s_rd    <= '0;
      s_data  <= '0;
      last    <= SRC_B;
    end else begin
      s_valid <= a_acc || b_acc;
      if (a_acc) begin
        s_rd   <= bus.a_rd;
        s_data <= bus.a_wdata;
        last   <= SRC_A;
      end else if (b_acc) begin
        s_rd   <= bus.b_rd;
        s_data <= bus.b_wdata;
        last   <= SRC_B;
      end
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed scoreboard bench for the writeback arbiter
module tb_regfile_wb_arbiter;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  typedef struct packed {
    logic        acc;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] d;
  } exp_t;
  exp_t q[$];
  regfile_wb_arbiter_if #(.XLEN(32), .REG_AW(5)) bus ();
  regfile_wb_arbiter #(.XLEN(32), .REG_AW(5)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  // One cycle: drive, check ready, push expected stage, clock, pop and compare outputs
  task automatic cyc(input string tag,
                     input logic av, input logic [4:0] ar, input logic [31:0] ad,
                     input logic bv, input logic [4:0] br, input logic [31:0] bd,
                     input logic hold, input logic ea, input logic eb);
    exp_t e;
    bus.a_valid = av; bus.a_rd = ar; bus.a_wdata = ad;
    bus.b_valid = bv; bus.b_rd = br; bus.b_wdata = bd;
    bus.wb_hold = hold;
    #1;
    chk({tag, ".a_ready"}, {31'b0, bus.a_ready}, {31'b0, ea});
    chk({tag, ".b_ready"}, {31'b0, bus.b_ready}, {31'b0, eb});
    e.acc = ea || eb;
    e.rd  = ea ? ar : br;
    e.d   = ea ? ad : bd;
    e.we  = e.acc && (e.rd != 5'd0);
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk({tag, ".reg_write"}, {31'b0, bus.reg_write}, {31'b0, e.we});
    if (e.acc) begin
      chk({tag, ".rd"}, {27'b0, bus.rd}, {27'b0, e.rd});
      chk({tag, ".rd_wdata"}, bus.rd_wdata, e.d);
    end
  endtask
  task automatic check_zero(input string tag);
    chk({tag, ".reg_write"}, {31'b0, bus.reg_write}, 32'd0);
    chk({tag, ".rd"}, {27'b0, bus.rd}, 32'd0);
    chk({tag, ".rd_wdata"}, bus.rd_wdata, 32'd0);
    chk({tag, ".a_ready"}, {31'b0, bus.a_ready}, 32'd0);
    chk({tag, ".b_ready"}, {31'b0, bus.b_ready}, 32'd0);
    chk({tag, ".rs1_fwd"}, {31'b0, bus.rs1_fwd}, 32'd0);
    chk({tag, ".rs1_fwd_data"}, bus.rs1_fwd_data, 32'd0);
  endtask
  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    q.delete();
    #1;
    check_zero(tag);
    @(negedge clk);
    reset_n = 1'b1;
  endtask
  initial begin
    bus.wb_hold = 1'b0;
    bus.a_valid = 1'b1; bus.a_rd = 5'd5; bus.a_wdata = 32'hDEADBEEF;
    bus.b_valid = 1'b1; bus.b_rd = 5'd6; bus.b_wdata = 32'h1;
    bus.rs1 = 5'd5; bus.rs2 = 5'd6;
    do_reset("reset0");
    bus.rs1 = 5'd0; bus.rs2 = 5'd0;
    cyc("singleA", 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0, 0, 1, 0);
    cyc("singleA_drain", 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 0);
    do_reset("reset1");
    cyc("rr1", 1, 5'd1, 32'h11, 1, 5'd3, 32'h33, 0, 1, 0);
    cyc("rr2", 1, 5'd2, 32'h22, 1, 5'd3, 32'h33, 0, 0, 1);
    cyc("rr3", 1, 5'd2, 32'h22, 1, 5'd4, 32'h44, 0, 1, 0);
    cyc("rr4", 0, 5'd0, 32'h0,  1, 5'd4, 32'h44, 0, 0, 1);
    cyc("bypA", 1, 5'd7, 32'hA5A5A5A5, 0, 5'd0, 32'h0, 0, 1, 0);
    bus.rs1 = 5'd7; bus.rs2 = 5'd8;
    #1;
    chk("byp.rs1_fwd", {31'b0, bus.rs1_fwd}, 32'd1);
    chk("byp.rs1_fwd_data", bus.rs1_fwd_data, 32'hA5A5A5A5);
    chk("byp.rs2_fwd", {31'b0, bus.rs2_fwd}, 32'd0);
    chk("byp.rs2_fwd_data", bus.rs2_fwd_data, 32'd0);
    cyc("byp_drain", 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 0);
    chk("byp_n2.rs1_fwd", {31'b0, bus.rs1_fwd}, 32'd0);
    chk("byp_n2.rs1_fwd_data", bus.rs1_fwd_data, 32'd0);
    cyc("x0B", 0, 5'd0, 32'h0, 1, 5'd0, 32'h1234, 0, 0, 1);
    bus.rs1 = 5'd0;
    #1;
    chk("x0.rs1_fwd", {31'b0, bus.rs1_fwd}, 32'd0);
    chk("x0.rs1_fwd_data", bus.rs1_fwd_data, 32'd0);
    cyc("hold1", 1, 5'd10, 32'hA0, 1, 5'd12, 32'hB0, 1, 0, 0);
    cyc("hold2", 1, 5'd10, 32'hA0, 1, 5'd12, 32'hB0, 1, 0, 0);
    cyc("hold3", 1, 5'd10, 32'hA0, 1, 5'd12, 32'hB0, 1, 0, 0);
    cyc("rel1", 1, 5'd10, 32'hA0, 1, 5'd12, 32'hB0, 0, 1, 0);
    cyc("rel2", 0, 5'd0,  32'h0,  1, 5'd12, 32'hB0, 0, 0, 1);
    cyc("preRst", 1, 5'd9, 32'h99, 0, 5'd0, 32'h0, 0, 1, 0);
    chk("preRst.rd", {27'b0, bus.rd}, 32'd9);
    bus.rs1 = 5'd9;
    bus.a_rd = 5'd11; bus.a_wdata = 32'hBB;
    do_reset("midRst");
    cyc("postRst", 1, 5'd11, 32'hBB, 0, 5'd0, 32'h0, 0, 1, 0);
    chk("postRst.rs1_fwd", {31'b0, bus.rs1_fwd}, 32'd0);
    cyc("final_drain", 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the register file's single write port between two writeback sources: A (ALU/execute) and B (load/LSU). Arbitrates round-robin with valid/ready handshakes and holds the winner in a one-entry write stage register that drives `reg_write`/`rd`/`rd_wdata` of the regfile. Provides combinational read-bypass outputs so decode reads see data still in the write stage. Sits between the execute/memory units and the regfile.

## Interface

- `XLEN`, 32, data width
- `REG_AW`, 5, register address width (2^REG_AW registers; x0 hard-wired zero)

- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `wb_hold`  in  1  1 = accept nothing this cycle
- `a_valid`  in  1  source A request
- `a_ready`  out  1  source A accepted this cycle
- `a_rd`  in  REG_AW  source A destination
- `a_wdata`  in  XLEN  source A data
- `b_valid` / `b_ready` / `b_rd` / `b_wdata`: same as A, for source B
- `reg_write`  out  1  regfile write enable
- `rd`  out  REG_AW  regfile write address
- `rd_wdata`  out  XLEN  regfile write data
- `rs1`, `rs2`  in  REG_AW  decode read addresses (same as regfile read ports)
- `rs1_fwd`, `rs2_fwd`  out  1  stage register holds a pending write to rs1/rs2
- `rs1_fwd_data`, `rs2_fwd_data`  out  XLEN  bypass data (0 when fwd is 0)

## Operation

- State: stage register S = {s_valid, s_rd, s_data}; round-robin pointer `last` (last granted source, A or B).
- Grant (combinational, same cycle):
  - `wb_hold`=1 or in reset: `a_ready`=`b_ready`=0.
  - Only one source valid: that source's ready=1.
  - Both valid: grant the source not equal to `last`.
  - Neither valid: both ready=0.
- Ready depends on valid, never the reverse. Sources hold valid, rd and wdata stable until accepted.
- Accept = valid && ready (at most one per cycle).
- On accept: S <= {1, rd, wdata} of the winner, and `last` <= winner. With no accept: s_valid <= 0, and `last` is unchanged.
- S always drains after one cycle, because the regfile never back-pressures.
- Outputs:
  - `reg_write` = s_valid && (s_rd != 0).
  - `rd` = s_rd; `rd_wdata` = s_data.
- Writes to x0 are accepted normally (handshake completes) but produce `reg_write`=0.
- Bypass:
  - `rsN_fwd` = s_valid && (s_rd != 0) && (s_rd == rsN).
  - `rsN_fwd_data` = `rsN_fwd` ? s_data : 0.
  - rsN = 0 never forwards.
- A and B targeting the same rd on successive accepts: writes commit in grant order, so the later grant wins.
- Reset (asynchronous assert, any time, including mid-transfer):
  - s_valid=0, s_rd=0, s_data=0, `last`=B, so A wins the first contention.
  - All outputs drop to 0 immediately.
  - A request in flight is not accepted. The source keeps valid and retries after reset release.

## Timing

- Reset values: `reg_write`=0, `rd`=0, `rd_wdata`=0, `a_ready`=`b_ready`=0, `rs1_fwd`=`rs2_fwd`=0, fwd data 0.
- Accept at edge N:
  - `reg_write`/`rd`/`rd_wdata` are valid during cycle N+1.
  - The regfile captures at edge N+1; regfile read returns new data from cycle N+1 after that edge, i.e. cycle N+2 onward.
  - `rsN_fwd` covers cycle N+1.
- Throughput: one write per cycle. Under continuous contention, grants alternate A, B, A, B…, so maximum wait is 1 cycle.
- `wb_hold` acts combinationally on ready in the same cycle. S empties at the next edge.
- Reset deassertion is synchronised externally to `clk`. The first accept is possible in the first cycle with `reset_n`=1.
- Paths: ready is combinational from valid/`wb_hold`; fwd is combinational from rs/S. All other outputs are registered.

## Test plan

- Reset then single A write:
  - Stimulus: `reset_n` low, then high. All outputs are 0 while low. Then a_valid=1, a_rd=5, a_wdata=0xDEADBEEF.
  - Response: `a_ready`=1 the same cycle. Next cycle `reg_write`=1, `rd`=5, `rd_wdata`=0xDEADBEEF. The cycle after, `reg_write`=0.
- Contention round-robin:
  - Stimulus: A and B both valid for 4 cycles (A rd=1/2, B rd=3/4), first contention after reset.
  - Response: grants go A, B, A, B, and `rd` sequence 1, 3, 2, 4 on consecutive cycles.
- x0 write:
  - Stimulus: b_valid=1, b_rd=0, b_wdata=0x1234.
  - Response: `b_ready`=1, next cycle `reg_write`=0, `rs1_fwd`=0 with rs1=0.
- Bypass:
  - Stimulus: accept A rd=7, data 0xA5A5A5A5; during cycle N+1 set rs1=7, rs2=8.
  - Response: `rs1_fwd`=1 with `rs1_fwd_data`=0xA5A5A5A5; `rs2_fwd`=0 with data 0. In cycle N+2, `rs1_fwd`=0.
- Hold:
  - Stimulus: `wb_hold`=1 with both sources valid for 3 cycles.
  - Response: ready stays 0, `reg_write`=0 from the 2nd cycle on. After release, A is granted first (`last` unchanged).
- Reset mid-operation:
  - Stimulus: assert `reset_n`=0 asynchronously while S is valid (rd=9).
  - Response: `reg_write`/`rd`/`rd_wdata` go to 0 before the next edge. A request held across reset is accepted in the first cycle after release.
